// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller:
// state encoding, direction codes and the default length limits.
package snake_pkg;

   localparam int unsigned INIT_LEN_DEF = 4;
   localparam int unsigned MAX_LEN_DEF  = 2047;
   localparam int unsigned LEN_W        = 11;

   // [2]=vertical, [1]=+y when vertical, [0]=+x when horizontal
   localparam logic [2:0] DIR_NEG_X = 3'b000;
   localparam logic [2:0] DIR_POS_X = 3'b001;
   localparam logic [2:0] DIR_NEG_Y = 3'b100;
   localparam logic [2:0] DIR_POS_Y = 3'b110;
   localparam logic [2:0] DIR_RESET = DIR_NEG_Y;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_HEAD,
      S_INIT_Q,
      S_DRAW_WAIT,
      S_DRAW,
      S_WAIT_TICK,
      S_UPD_HEAD,
      S_LD_PREV,
      S_RD_WAIT,
      S_LD_CURR,
      S_WR_Q,
      S_SWAP,
      S_DEAD
   } state_t;

   function automatic logic is_reversal(input logic [2:0] cur, input logic [2:0] req);
      logic both_vert;
      logic both_horz;
      both_vert = cur[2] & req[2];
      both_horz = ~cur[2] & ~req[2];
      return (both_vert & (cur[1] ^ req[1])) | (both_horz & (cur[0] ^ req[0]));
   endfunction

endpackage

// File: rtl/snake_control_if.sv
// Signal bundle between the snake controller and its datapath/game logic.
interface snake_control_if;

   logic        go;
   logic        tick;
   logic [2:0]  dir_req;
   logic        grow;
   logic        is_dead;

   logic        ld_head;
   logic        ld_q_def;
   logic        inc_address;
   logic        rst_address;
   logic        draw_q;
   logic        update_head;
   logic        ld_head_into_prev;
   logic        ld_q_into_curr;
   logic        ld_prev_into_q;
   logic        ld_curr_into_prev;
   logic        draw_curr;
   logic [1:0]  cnt_status;
   logic [2:0]  dir;
   logic        busy;
   logic        frame_done;
   logic [10:0] len;

   modport slave (
      input  go, tick, dir_req, grow, is_dead,
      output ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
             ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
             draw_curr, cnt_status, dir, busy, frame_done, len
   );

   modport master (
      output go, tick, dir_req, grow, is_dead,
      input  ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
             ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
             draw_curr, cnt_status, dir, busy, frame_done, len
   );

endinterface

// File: rtl/snake_dir_guard.sv
// Direction filter: passes the requested direction unless it would turn the
// snake straight back onto itself, in which case the current one is kept.
module snake_dir_guard
   import snake_pkg::*;
(
   input  logic [2:0] cur_dir_i,
   input  logic [2:0] req_dir_i,
   output logic [2:0] next_dir_o
);

   always_comb begin
      next_dir_o = is_reversal(cur_dir_i, req_dir_i) ? cur_dir_i : req_dir_i;
   end

endmodule

// File: rtl/snake_control.sv
// Snake game controller: sequences head load, body init, per-frame redraw and
// the per-move body shift loop; all datapath strobes decode from state.
module snake_control
   import snake_pkg::*;
#(
   parameter int unsigned INIT_LEN = INIT_LEN_DEF,
   parameter int unsigned MAX_LEN  = MAX_LEN_DEF
)(
   input logic             clk,
   input logic             rst,
   snake_control_if.slave  bus
);

   localparam logic [LEN_W-1:0] INIT_L = LEN_W'(INIT_LEN);
   localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [2:0]       dir_q, dir_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             g_q, g_d;

   logic [2:0]       dir_guarded;

   logic ld_head_c, ld_q_def_c, inc_c, rst_addr_c, draw_q_c, update_head_c;
   logic ld_head_into_prev_c, ld_q_into_curr_c, ld_prev_into_q_c, ld_curr_into_prev_c;
   logic frame_done_c, pend_clr_c;

   snake_dir_guard u_dir_guard (
      .cur_dir_i  (dir_q),
      .req_dir_i  (bus.dir_req),
      .next_dir_o (dir_guarded)
   );

   always_comb begin
      state_d             = state_q;
      len_d               = len_q;
      dir_d               = dir_q;
      cnt_d               = cnt_q;
      g_d                 = g_q;
      idx_d               = idx_q;
      pend_d              = pend_q;
      ld_head_c           = 1'b0;
      ld_q_def_c          = 1'b0;
      inc_c               = 1'b0;
      rst_addr_c          = 1'b0;
      draw_q_c            = 1'b0;
      update_head_c       = 1'b0;
      ld_head_into_prev_c = 1'b0;
      ld_q_into_curr_c    = 1'b0;
      ld_prev_into_q_c    = 1'b0;
      ld_curr_into_prev_c = 1'b0;
      frame_done_c        = 1'b0;
      pend_clr_c          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.go) state_d = S_LD_HEAD;
         end
         S_LD_HEAD: begin
            ld_head_c  = 1'b1;
            rst_addr_c = 1'b1;
            len_d      = INIT_L;
            dir_d      = DIR_RESET;
            state_d    = S_INIT_Q;
         end
         S_INIT_Q: begin
            ld_q_def_c = 1'b1;
            inc_c      = 1'b1;
            if (idx_q == INIT_L - LEN_W'(1)) begin
               rst_addr_c = 1'b1;
               state_d    = S_DRAW_WAIT;
            end
         end
         S_DRAW_WAIT: begin
            state_d = S_DRAW;
         end
         S_DRAW: begin
            draw_q_c = 1'b1;
            cnt_d    = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               inc_c = 1'b1;
               if (idx_q == len_q - LEN_W'(1)) begin
                  frame_done_c = 1'b1;
                  rst_addr_c   = 1'b1;
                  state_d      = S_WAIT_TICK;
               end else begin
                  state_d = S_DRAW_WAIT;
               end
            end
         end
         S_WAIT_TICK: begin
            if (bus.is_dead) begin
               state_d = S_DEAD;
            end else if (bus.tick) begin
               dir_d   = dir_guarded;
               state_d = S_UPD_HEAD;
            end
         end
         S_UPD_HEAD: begin
            update_head_c = 1'b1;
            state_d       = S_LD_PREV;
         end
         S_LD_PREV: begin
            ld_head_into_prev_c = 1'b1;
            rst_addr_c          = 1'b1;
            // growth decision is frozen here so the loop bound is stable
            g_d                 = pend_q && (len_q < MAX_L);
            state_d             = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            state_d = S_LD_CURR;
         end
         S_LD_CURR: begin
            ld_q_into_curr_c = 1'b1;
            state_d          = S_WR_Q;
         end
         S_WR_Q: begin
            ld_prev_into_q_c = 1'b1;
            state_d          = S_SWAP;
         end
         S_SWAP: begin
            ld_curr_into_prev_c = 1'b1;
            inc_c               = 1'b1;
            if (idx_q == len_q + LEN_W'(g_q) - LEN_W'(1)) begin
               len_d      = len_q + LEN_W'(g_q);
               pend_clr_c = 1'b1;
               rst_addr_c = 1'b1;
               state_d    = S_DRAW_WAIT;
            end else begin
               state_d = S_RD_WAIT;
            end
         end
         S_DEAD: begin
            if (bus.go) state_d = S_LD_HEAD;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rst_addr_c)     idx_d = '0;
      else if (inc_c)     idx_d = idx_q + LEN_W'(1);

      if (pend_clr_c)     pend_d = 1'b0;
      if (bus.grow && (len_q < MAX_L)) pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= INIT_L;
         dir_q   <= DIR_RESET;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         g_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         g_q     <= g_d;
      end
   end

   assign bus.ld_head           = ld_head_c;
   assign bus.ld_q_def          = ld_q_def_c;
   assign bus.inc_address       = inc_c;
   assign bus.rst_address       = rst_addr_c;
   assign bus.draw_q            = draw_q_c;
   assign bus.update_head       = update_head_c;
   assign bus.ld_head_into_prev = ld_head_into_prev_c;
   assign bus.ld_q_into_curr    = ld_q_into_curr_c;
   assign bus.ld_prev_into_q    = ld_prev_into_q_c;
   assign bus.ld_curr_into_prev = ld_curr_into_prev_c;
   // no state in the sequence drives the current-segment draw strobe
   assign bus.draw_curr         = 1'b0;
   assign bus.frame_done        = frame_done_c;
   assign bus.cnt_status        = cnt_q;
   assign bus.dir               = dir_q;
   assign bus.len               = len_q;
   assign bus.busy              = !((state_q == S_IDLE) || (state_q == S_WAIT_TICK) ||
                                    (state_q == S_DEAD));

endmodule

// File: tb/tb_snake_control.sv
// Scoreboard bench for snake_control: stimulus queues expected per-frame
// strobe counts; a negedge monitor accumulates and checks them at frame_done.
module tb_snake_control;

   logic clk;
   logic rst;

   snake_control_if bus ();

   snake_control #(.INIT_LEN(4), .MAX_LEN(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int len;
      int dir;
      int ldhead;
      int ldqdef;
      int uh;
      int pq;
   } frame_t;

   frame_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int frames   = 0;

   int acc_ldhead, acc_ldqdef, acc_uh, acc_pq, acc_qc, acc_draw, redraw_cnt;
   logic bad_phase;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic clear_acc();
      acc_ldhead = 0; acc_ldqdef = 0; acc_uh = 0; acc_pq = 0; acc_qc = 0;
      acc_draw = 0; bad_phase = 1'b0;
   endtask

   // monitor
   always @(negedge clk) begin
      frame_t e;
      if (rst) begin
         clear_acc();
         redraw_cnt = 0;
      end else begin
         if (bus.ld_head)        acc_ldhead++;
         if (bus.ld_q_def)       acc_ldqdef++;
         if (bus.update_head)    acc_uh++;
         if (bus.ld_prev_into_q) acc_pq++;
         if (bus.ld_q_into_curr) acc_qc++;
         if (bus.draw_q) begin
            if (int'(bus.cnt_status) != (acc_draw % 4)) bad_phase = 1'b1;
            acc_draw++;
         end
         if (bus.frame_done) begin
            frames++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_frame: got frame %0d with nothing queued", frames);
            end else begin
               e = exp_q.pop_front();
               chk("len",        int'(bus.len), e.len);
               chk("dir",        int'(bus.dir), e.dir);
               chk("ld_head",    acc_ldhead,    e.ldhead);
               chk("ld_q_def",   acc_ldqdef,    e.ldqdef);
               chk("update_hd",  acc_uh,        e.uh);
               chk("prev_to_q",  acc_pq,        e.pq);
               chk("q_to_curr",  acc_qc,        e.pq);
               chk("draw_q",     acc_draw,      4 * e.len);
               chk("redraw_cyc", redraw_cnt + 1, 5 * e.len);
               chk("cnt_phase",  int'(bad_phase), 0);
            end
            clear_acc();
         end
         if (bus.rst_address) redraw_cnt = 0;
         else                 redraw_cnt++;
      end
   end

   task automatic push(input int len, input int dir, input int ldhead, input int ldqdef,
                       input int uh, input int pq);
      frame_t f;
      f.len = len; f.dir = dir; f.ldhead = ldhead; f.ldqdef = ldqdef; f.uh = uh; f.pq = pq;
      exp_q.push_back(f);
   endtask

   task automatic pulse_go();
      @(posedge clk); #1 bus.go = 1'b1;
      @(posedge clk); #1 bus.go = 1'b0;
   endtask

   task automatic pulse_grow();
      @(posedge clk); #1 bus.grow = 1'b1;
      @(posedge clk); #1 bus.grow = 1'b0;
   endtask

   task automatic do_tick(input logic [2:0] d);
      @(posedge clk); #1 bus.dir_req = d; bus.tick = 1'b1;
      @(posedge clk); #1 bus.tick = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int target;
      bit ok;
      target = frames + n;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (frames >= target) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL frame_timeout: got %0d frames expected %0d", frames, target);
      end
   endtask

   task automatic check_quiet(input string name, input int exp_dir);
      logic [12:0] ctl;
      ctl = {bus.ld_head, bus.ld_q_def, bus.inc_address, bus.rst_address, bus.draw_q,
             bus.update_head, bus.ld_head_into_prev, bus.ld_q_into_curr, bus.ld_prev_into_q,
             bus.ld_curr_into_prev, bus.draw_curr, bus.frame_done, bus.busy};
      chk({name, "_ctl"}, int'(ctl), 0);
      chk({name, "_len"}, int'(bus.len), 4);
      chk({name, "_dir"}, int'(bus.dir), exp_dir);
      chk({name, "_cnt"}, int'(bus.cnt_status), 0);
   endtask

   initial begin
      int f0;
      bit found;
      bus.go = 1'b0; bus.tick = 1'b0; bus.dir_req = 3'b000; bus.grow = 1'b0; bus.is_dead = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset", 3'b100);
      @(posedge clk); #1 rst = 1'b0;

      // start: head, 4 init writes, 20-cycle redraw
      push(4, 3'b100, 1, 4, 0, 0);
      pulse_go();
      wait_frames(1);

      // vertical reversal rejected
      push(4, 3'b100, 0, 0, 1, 4);
      do_tick(3'b110);
      wait_frames(1);

      // turn to +x
      push(4, 3'b001, 0, 0, 1, 4);
      do_tick(3'b001);
      wait_frames(1);

      // horizontal reversal rejected
      push(4, 3'b001, 0, 0, 1, 4);
      do_tick(3'b000);
      wait_frames(1);

      // turn to +y; stray go and tick while busy are ignored
      push(4, 3'b110, 0, 0, 1, 4);
      do_tick(3'b110);
      pulse_go();
      repeat (3) @(posedge clk);
      do_tick(3'b000);
      wait_frames(1);
      f0 = frames;
      pulse_go();
      repeat (10) @(negedge clk);
      chk("go_in_wait_busy", int'(bus.busy), 0);
      chk("go_in_wait_frames", frames, f0);

      // double grow counts once
      pulse_grow();
      pulse_grow();
      push(5, 3'b110, 0, 0, 1, 5);
      do_tick(3'b110);
      wait_frames(1);

      // grow at MAX_LEN ignored
      pulse_grow();
      push(5, 3'b001, 0, 0, 1, 5);
      do_tick(3'b001);
      wait_frames(1);

      // death beats tick
      f0 = frames;
      @(posedge clk); #1 bus.is_dead = 1'b1; bus.dir_req = 3'b000; bus.tick = 1'b1;
      @(posedge clk); #1 bus.tick = 1'b0;
      repeat (8) @(negedge clk);
      chk("dead_busy", int'(bus.busy), 0);
      chk("dead_uh", acc_uh, 0);
      chk("dead_no_frame", frames, f0);
      chk("dead_len_kept", int'(bus.len), 5);
      #1 bus.is_dead = 1'b0;
      push(4, 3'b100, 1, 4, 0, 0);
      pulse_go();
      wait_frames(1);

      // reset in WR_Q with grow pending
      pulse_grow();
      do_tick(3'b001);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.ld_prev_into_q) begin
            found = 1'b1;
            break;
         end
      end
      chk("wr_q_seen", int'(found), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_quiet("midloop_rst", 3'b100);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_quiet("after_rst", 3'b100);

      push(4, 3'b100, 1, 4, 0, 0);
      pulse_go();
      wait_frames(1);
      push(4, 3'b001, 0, 0, 1, 4);
      do_tick(3'b001);
      wait_frames(1);

      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/snake_control.md
SNAKE_CONTROL -- requirements
Module: snake_control

Interface
REQ-001 SHALL have parameter INIT_LEN, default 4: segments written at game start (1..MAX_LEN).
REQ-002 SHALL have parameter MAX_LEN, default 2047: length saturation limit (fits 11-bit address).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port go, input, 1: start/restart request, sampled in IDLE and DEAD.
REQ-006 SHALL have port tick, input, 1: one-cycle game-step pulse, sampled only in WAIT_TICK.
REQ-007 SHALL have port dir_req, input, 3: requested direction; [2]=vertical, [1]=+y when vertical, [0]=+x when horizontal.
REQ-008 SHALL have port grow, input, 1: pulse; the next move lengthens the snake by one.
REQ-009 SHALL have port is_dead, input, 1: collision flag from the datapath.
REQ-010 SHALL have ports ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, output, 1 each: datapath controls.
REQ-011 SHALL have port cnt_status, output, 2: pixel offset within a 2x2 segment block.
REQ-012 SHALL have port dir, output, 3: registered direction applied on update_head.
REQ-013 SHALL have ports busy (1: not in IDLE/WAIT_TICK/DEAD), frame_done (1-cycle pulse at end of redraw) and len (11: current length), outputs.

Function
REQ-014 SHALL implement states IDLE, LD_HEAD, INIT_Q, DRAW_WAIT, DRAW, WAIT_TICK, UPD_HEAD, LD_PREV, RD_WAIT, LD_CURR, WR_Q, SWAP and DEAD.
REQ-015 SHALL decode all datapath controls combinationally from state; every control SHALL be 0 in states that do not name it.
REQ-016 SHALL keep an internal 11-bit idx that mirrors the datapath address: cleared by rst_address and incremented by inc_address, in the same cycles.
REQ-017 IDLE -> LD_HEAD on go; LD_HEAD asserts ld_head and rst_address for one cycle, sets len=INIT_LEN and dir=3'b100.
REQ-018 INIT_Q SHALL assert ld_q_def and inc_address for exactly INIT_LEN cycles, then go to DRAW_WAIT with rst_address.
REQ-019 Per segment, DRAW_WAIT (1 cycle, RAM read latency) SHALL be followed by DRAW for 4 cycles with draw_q=1 and cnt_status 0,1,2,3; the 4th DRAW cycle SHALL assert inc_address.
REQ-020 After the segment with idx=len-1, the block SHALL pulse frame_done, assert rst_address and go to WAIT_TICK; a redraw therefore takes 5*len cycles.
REQ-021 In WAIT_TICK, is_dead=1 SHALL transition to DEAD (priority over tick); otherwise tick SHALL latch dir_req into dir unless it is a reversal, then go to UPD_HEAD.
REQ-022 A reversal is: both vertical with differing bit[1], or both horizontal with differing bit[0]; on a reversal, dir SHALL hold its value.
REQ-023 UPD_HEAD (1 cycle) SHALL assert update_head; LD_PREV (1 cycle) SHALL assert ld_head_into_prev and rst_address.
REQ-024 The shift loop SHALL cycle RD_WAIT -> LD_CURR (ld_q_into_curr) -> WR_Q (ld_prev_into_q) -> SWAP (ld_curr_into_prev, inc_address) at 4 cycles per slot.
REQ-025 The shift loop SHALL run len+g iterations, where g=1 if grow is pending and len<MAX_LEN; on exit, len SHALL be increased by g, the pending flag cleared and the block SHALL go to DRAW_WAIT with rst_address.
REQ-026 A grow pulse in any state SHALL set the pending flag; multiple pulses before one move SHALL count as one; grow at len=MAX_LEN SHALL be ignored.
REQ-027 DEAD SHALL hold all controls at 0 and go to LD_HEAD on go, which restarts the game with len=INIT_LEN.
REQ-028 A go or tick outside its sampling state SHALL be ignored.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=IDLE, idx=0, len=INIT_LEN, dir=3'b100, cnt_status=0, grow-pending=0, and all outputs 0 (len output = INIT_LEN), including when rst arrives mid-loop.

Structure
REQ-030 State encoding, direction encoding constants and the INIT_LEN/MAX_LEN defaults SHALL live in shared package snake_pkg.
REQ-031 Reversal filtering SHALL be one combinational sub-module, snake_dir_guard; all other logic is flat.

Verification
REQ-032 rst, then go with INIT_LEN=4 -> ld_head 1 cycle, ld_q_def 4 cycles, then 20 redraw cycles and a frame_done pulse.
REQ-033 tick with dir_req=3'b001 -> dir=001; update_head 1 cycle, then 4x4 shift cycles with ld_prev_into_q asserted 4 times, then redraw.
REQ-034 dir=3'b100, tick with dir_req=3'b110 -> dir stays 100 (reversal rejected).
REQ-035 grow pulsed twice, then tick -> 5 shift iterations, len=5, next redraw is 25 cycles; with len=MAX_LEN, grow leaves len unchanged.
REQ-036 is_dead=1 and tick in the same WAIT_TICK cycle -> DEAD, no update_head; then go -> LD_HEAD and len=INIT_LEN.
REQ-037 rst asserted during WR_Q -> next cycle IDLE, all controls 0, len=INIT_LEN.
